// File: rtl/sample_pair_packer.sv
// sample_pair_packer: packs pairs of signed samples into double-width words
// and buffers them in a small first-word-fall-through FIFO.
// Ports:
//   clk, nrst               clock (rising edge), async active-low reset
//   in_valid/in_ready       sample handshake; in_data is one signed sample
//   in_last                 closes a packet; a lone pending sample leaves as a half word
//   out_valid/out_ready     FIFO head handshake toward egress
//   out_data/keep/last      head word; first sample in the low lane
//   fifo_level              occupied FIFO entries
//   word_cnt                words popped since reset (wraps)
module sample_pair_packer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DOUT_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned AW         = 2
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DOUT_WIDTH-1:0]        out_data,
  output logic [1:0]                   out_keep,
  output logic                         out_last,
  output logic [AW:0]                  fifo_level,
  output logic [15:0]                  word_cnt
);

  localparam int unsigned PadW = DOUT_WIDTH - DATA_WIDTH;

  typedef enum logic {
    IDLE = 1'b0,
    HALF = 1'b1
  } state_t;

  typedef struct packed {
    logic [DOUT_WIDTH-1:0] data;
    logic [1:0]            keep;
    logic                  last;
  } word_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  word_t                 mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [AW:0]           level_q, level_d;
  logic [15:0]           word_cnt_q;

  logic  accept, pop, push;
  word_t push_word;

  // Handshake flags depend only on registered occupancy; no path from out_ready.
  assign in_ready  = (level_q != (AW+1)'(FIFO_DEPTH));
  assign out_valid = (level_q != '0);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Pairing FSM: next state, hold register and the word to push.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    push      = 1'b0;
    push_word = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_last) begin
            // Lone sample: upper lane is zero, not sign-extended.
            push           = 1'b1;
            push_word.data = {{PadW{1'b0}}, in_data};
            push_word.keep = 2'b01;
            push_word.last = 1'b1;
          end else begin
            hold_d  = in_data;
            state_d = HALF;
          end
        end
      end
      HALF: begin
        if (accept) begin
          push           = 1'b1;
          push_word.data = {in_data, hold_q};
          push_word.keep = 2'b11;
          push_word.last = in_last;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Occupancy update; simultaneous push and pop cancel out.
  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + (AW+1)'(1);
    end else if (pop && !push) begin
      level_d = level_q - (AW+1)'(1);
    end
  end

  // FSM and hold register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // FIFO storage, pointers, occupancy and pop counter.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      word_cnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_word;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q   <= rd_ptr_q + AW'(1);
        word_cnt_q <= word_cnt_q + 16'd1;
      end
      level_q <= level_d;
    end
  end

  // Head entry drives the output payload directly (fall-through).
  assign out_data   = mem_q[rd_ptr_q].data;
  assign out_keep   = mem_q[rd_ptr_q].keep;
  assign out_last   = mem_q[rd_ptr_q].last;
  assign fifo_level = level_q;
  assign word_cnt   = word_cnt_q;

endmodule

// File: tb/tb_sample_pair_packer.sv
// Scoreboard bench for sample_pair_packer: stimulus pushes expected words,
// a monitor pops and compares on every output handshake.
module tb_sample_pair_packer;

  logic        clk;
  logic        nrst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [1:0]  out_keep;
  logic        out_last;
  logic [2:0]  fifo_level;
  logic [15:0] word_cnt;

  typedef struct packed {
    logic [15:0] d;
    logic [1:0]  k;
    logic        l;
  } exp_t;

  exp_t       sb_q[$];
  int         checks = 0;
  int         errors = 0;
  logic       m_half = 1'b0;
  logic [7:0] m_held = 8'h00;
  logic       rnd_done = 1'b0;

  sample_pair_packer #(
    .DATA_WIDTH(8), .DOUT_WIDTH(16), .FIFO_DEPTH(4), .AW(2)
  ) dut (
    .clk(clk), .nrst(nrst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_keep(out_keep), .out_last(out_last),
    .fifo_level(fifo_level), .word_cnt(word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference pairing model.
  task automatic model_accept(input logic [7:0] d, input logic l);
    if (m_half) begin
      sb_q.push_back({d, m_held, 2'b11, l});
      m_half = 1'b0;
    end else if (l) begin
      sb_q.push_back({8'h00, d, 2'b01, 1'b1});
    end else begin
      m_held = d;
      m_half = 1'b1;
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (nrst && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got %h/%b/%b expected nothing", out_data, out_keep, out_last);
        end else begin
          e = sb_q.pop_front();
          chk("sb_word", 32'({out_data, out_keep, out_last}), 32'(e));
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offers one sample; returns 1 ns after the accepting edge.
  task automatic send(input logic [7:0] d, input logic l);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("send_accept", 32'(in_ready), 32'd1);
    if (in_ready) model_accept(d, l);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    @(negedge clk);
    while ((sb_q.size() != 0 || out_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 32'(sb_q.size()), 32'd0);
    chk("drain_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    nrst     = 1'b0;
    in_valid = 1'b0;
    sb_q.delete();
    m_half   = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_keep", 32'(out_keep), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_word_cnt", 32'(word_cnt), 32'd0);
    @(posedge clk);
    #1;
    nrst = 1'b1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    idle(1);
  endtask

  initial begin
    nrst      = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    out_ready = 1'b0;
    fork
      monitor();
    join_none
    #2;
    apply_reset();

    // Reset mid-stream: one full word queued plus a held sample, then async reset.
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h33, 1'b0);
    chk("pre_rst_level", 32'(fifo_level), 32'd1);
    #2;
    apply_reset();
    // Held 8'h33 must be gone: a lone sample now forms a half word.
    out_ready = 1'b1;
    send(8'h55, 1'b1);
    wait_drain();

    // Pair pack with one-cycle latency.
    send(8'h12, 1'b0);
    @(negedge clk);
    chk("pair_not_yet", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    send(8'h34, 1'b0);
    @(negedge clk);
    chk("pair_latency", 32'(out_valid), 32'd1);
    chk("pair_data", 32'(out_data), 32'h3412);
    chk("pair_keep", 32'(out_keep), 32'b11);
    @(posedge clk);
    #1;
    wait_drain();

    // Flush: paired last and lone last.
    send(8'hA5, 1'b0);
    send(8'h7F, 1'b1);
    send(8'h80, 1'b1);
    wait_drain();

    // Backpressure: fill, refuse while full, then full-with-pop.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(8'(8'h10 + i), 1'b0);
    @(negedge clk);
    chk("bp_level_full", 32'(fifo_level), 32'd4);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = 8'hC9;
    in_last  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_refuse", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    chk("bp_level_hold", 32'(fifo_level), 32'd4);
    out_ready = 1'b1;
    @(negedge clk);
    chk("full_pop_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("full_pop_level", 32'(fifo_level), 32'd3);
    @(negedge clk);
    chk("resume_in_ready", 32'(in_ready), 32'd1);
    if (in_ready) model_accept(8'hC9, 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    send(8'hCA, 1'b1);
    wait_drain();

    // Random valid/ready traffic.
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          idle($urandom_range(0, 2));
          send(8'($urandom), ($urandom_range(0, 3) == 0));
        end
        send(8'hFE, 1'b1);
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();

    // Pop counter wrap.
    #2;
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 65535; i++) send(8'(i), 1'b1);
    wait_drain();
    chk("cnt_ffff", 32'(word_cnt), 32'h0000FFFF);
    send(8'hEE, 1'b1);
    wait_drain();
    chk("cnt_wrap", 32'(word_cnt), 32'd0);
    chk("end_level", 32'(fifo_level), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
